// File: rtl/friscv_clint_mh.sv
// Multi-hart CLINT: shared 64-bit MTIME, per-hart MTIMECMP/MSIP, APB slave access.
// Optional FRISCV_CLINT_SNAPSHOT_EN (XLEN=32): a low-word MTIME read latches the high word.
module friscv_clint_mh #(
    parameter int unsigned ADDRW      = 16,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NHART      = 4,
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              slv_en,
    input  logic              slv_wr,
    input  logic [ADDRW-1:0]  slv_addr,
    input  logic [XLEN-1:0]   slv_wdata,
    input  logic [XLEN/8-1:0] slv_strb,
    output logic [XLEN-1:0]   slv_rdata,
    output logic              slv_ready,
    output logic              slv_err,
    input  logic              rtc,
    output logic [NHART-1:0]  sw_irq,
    output logic [NHART-1:0]  timer_irq
);

    localparam logic [ADDRW-1:0] MsipEnd  = ADDRW'(4 * NHART);
    localparam logic [ADDRW-1:0] CmpBase  = ADDRW'(16'h4000);
    localparam logic [ADDRW-1:0] CmpSpan  = ADDRW'(8 * NHART);
    localparam logic [ADDRW-1:0] MtimeAdr = ADDRW'(16'hBFF8);

    logic [SYNC_DEPTH-1:0] rtc_sync_q;
    logic                  rtc_prev_q, tick_q;

    logic [63:0]      mtime_q, mtime_d, mtime_rd;
    logic [63:0]      cmp_q [NHART];
    logic [63:0]      cmp_d [NHART];
    logic [NHART-1:0] msip_q, msip_d, timer_q;
    logic [NHART-1:0] msip_sel, cmp_sel;
    logic             ready_q, err_q;
    logic [XLEN-1:0]  rdata_q, rd_word;

    logic             access, wr_go, ok32, ok64, err;
    logic             msip_hit, cmp_hit, mtime_hit, mtime_wr;
    logic             msip_wbit, msip_wstb;
    logic [ADDRW-1:0] cmp_off;
    logic [4:0]       msip_idx, cmp_idx;
    logic [63:0]      wdata64, wmask64, rd64;
    logic [7:0]       wstrb64;

    assign access    = slv_en & ~ready_q;
    assign wr_go     = access & slv_wr;
    assign ok32      = (slv_addr[1:0] == 2'b00);
    assign ok64      = ok32 & ((XLEN == 32) | ~slv_addr[2]);
    assign cmp_off   = slv_addr - CmpBase;
    assign msip_hit  = ok32 && (slv_addr < MsipEnd);
    assign cmp_hit   = ok64 && (cmp_off < CmpSpan);
    assign mtime_hit = ok64 && (slv_addr[ADDRW-1:3] == MtimeAdr[ADDRW-1:3]);
    assign msip_idx  = slv_addr[6:2];
    assign cmp_idx   = cmp_off[7:3];
    assign err       = ~(msip_hit | cmp_hit | mtime_hit);

    // Bus data is mapped into a 64-bit register view so one merge path serves both XLENs.
    if (XLEN == 32) begin : g_x32
        assign wdata64 = {slv_wdata, slv_wdata};
        assign wstrb64 = slv_addr[2] ? {slv_strb, 4'b0000} : {4'b0000, slv_strb};
        assign rd_word = slv_addr[2] ? rd64[63:32] : rd64[31:0];
    end else begin : g_x64
        assign wdata64 = slv_wdata;
        assign wstrb64 = slv_strb;
        assign rd_word = rd64;
    end

    always_comb begin
        for (int unsigned b = 0; b < 8; b++) begin
            wmask64[8*b +: 8] = {8{wstrb64[b]}};
        end
    end

    assign msip_wbit = slv_addr[2] ? wdata64[32] : wdata64[0];
    assign msip_wstb = slv_addr[2] ? wstrb64[4] : wstrb64[0];
    assign mtime_wr  = wr_go & mtime_hit & (|wstrb64);

    always_comb begin
        msip_d = msip_q;
        rd64   = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            msip_sel[h] = msip_hit && (msip_idx == 5'(h));
            cmp_sel[h]  = cmp_hit && (cmp_idx == 5'(h));
            cmp_d[h]    = (wr_go && cmp_sel[h]) ?
                          ((cmp_q[h] & ~wmask64) | (wdata64 & wmask64)) : cmp_q[h];
            if (wr_go && msip_sel[h] && msip_wstb) msip_d[h] = msip_wbit;
            if (msip_sel[h]) begin
                rd64 = slv_addr[2] ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
            end
            if (cmp_sel[h]) rd64 = cmp_q[h];
        end
        if (mtime_hit) rd64 = mtime_rd;
    end

    // A bus write to MTIME takes precedence over a concurrent tick.
    always_comb begin
        mtime_d = mtime_q;
        if (mtime_wr) begin
            mtime_d = (mtime_q & ~wmask64) | (wdata64 & wmask64);
        end else if (tick_q) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            rtc_sync_q <= '0;
            rtc_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            rtc_sync_q <= {rtc_sync_q[SYNC_DEPTH-2:0], rtc};
            rtc_prev_q <= rtc_sync_q[SYNC_DEPTH-1];
            tick_q     <= rtc_sync_q[SYNC_DEPTH-1] & ~rtc_prev_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            mtime_q <= '0;
            msip_q  <= '0;
            timer_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int unsigned h = 0; h < NHART; h++) cmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_d;
            msip_q  <= msip_d;
            ready_q <= access;
            for (int unsigned h = 0; h < NHART; h++) begin
                cmp_q[h]   <= cmp_d[h];
                timer_q[h] <= (mtime_q >= cmp_q[h]);
            end
            if (access) begin
                rdata_q <= rd_word;
                err_q   <= err;
            end
        end
    end

`ifdef FRISCV_CLINT_SNAPSHOT_EN
    logic [31:0] shadow_q;

    always_ff @(posedge aclk) begin
        if (srst) begin
            shadow_q <= '0;
        end else if (mtime_wr) begin
            shadow_q <= mtime_d[63:32];
        end else if (access && !slv_wr && mtime_hit && !slv_addr[2]) begin
            shadow_q <= mtime_q[63:32];
        end
    end

    assign mtime_rd = (XLEN == 32) ? {shadow_q, mtime_q[31:0]} : mtime_q;
`else
    assign mtime_rd = mtime_q;
`endif

    assign slv_rdata = rdata_q;
    assign slv_ready = ready_q;
    assign slv_err   = err_q;
    assign sw_irq    = msip_q;
    assign timer_irq = timer_q;

endmodule

// File: tb/tb_friscv_clint_mh.sv
// Directed self-checking bench for friscv_clint_mh (XLEN=32, NHART=4, SYNC_DEPTH=2).
module tb_friscv_clint_mh;

    localparam int unsigned SYNC_DEPTH = 2;

    logic        aclk = 1'b0;
    logic        srst = 1'b1;
    logic        slv_en = 1'b0;
    logic        slv_wr = 1'b0;
    logic [15:0] slv_addr = '0;
    logic [31:0] slv_wdata = '0;
    logic [3:0]  slv_strb = '0;
    logic        rtc = 1'b0;
    logic [31:0] slv_rdata;
    logic        slv_ready, slv_err;
    logic [3:0]  sw_irq, timer_irq;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    friscv_clint_mh #(
        .ADDRW      (16),
        .XLEN       (32),
        .NHART      (4),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) dut (
        .aclk      (aclk),
        .srst      (srst),
        .slv_en    (slv_en),
        .slv_wr    (slv_wr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_strb  (slv_strb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready),
        .slv_err   (slv_err),
        .rtc       (rtc),
        .sw_irq    (sw_irq),
        .timer_irq (timer_irq)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        @(posedge aclk); #1;
        slv_en = 1'b1; slv_wr = wr; slv_addr = a; slv_wdata = d; slv_strb = s;
        do begin
            @(posedge aclk); #1;
            n++;
        end while (!slv_ready && n < 8);
        if (!slv_ready) begin
            total++; bad++;
            $display("FAIL handshake: no slv_ready for addr %h, got 0 required 1", a);
        end
        rd = slv_rdata;
        er = slv_err;
        slv_en = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic er);
        logic [31:0] unused;
        xfer(1'b1, a, d, s, unused, er);
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] rd, output logic er);
        xfer(1'b0, a, 32'h0, 4'h0, rd, er);
    endtask

    task automatic pulse;
        @(posedge aclk); #1;
        rtc = 1'b1;
        repeat (4) begin @(posedge aclk); #1; end
        rtc = 1'b0;
        repeat (4) begin @(posedge aclk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        // Access pending while reset is held must be dropped.
        slv_en = 1'b1; slv_wr = 1'b1; slv_addr = 16'h0000; slv_wdata = 32'h1; slv_strb = 4'hf;
        srst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk); #1;
            total++;
            if (slv_ready !== 1'b0) begin
                bad++; $display("FAIL reset_ready: got %b required 0", slv_ready);
            end
        end
        srst = 1'b0; slv_en = 1'b0;
        total++;
        if (slv_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", slv_rdata); end
        total++;
        if (slv_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", slv_err); end
        total++;
        if (sw_irq !== 4'h0) begin bad++; $display("FAIL reset_sw_irq: got %b required 0000", sw_irq); end
        total++;
        if (timer_irq !== 4'h0) begin bad++; $display("FAIL reset_timer_irq: got %b required 0000", timer_irq); end
        @(posedge aclk); #1;
        total++;
        if (slv_ready !== 1'b0) begin bad++; $display("FAIL reset_abort: got %b required 0", slv_ready); end
        apb_read(16'h4000, rd, er);
        total++;
        if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin
            bad++; $display("FAIL reset_cmp0_lo: got %h/%b required ffffffff/0", rd, er);
        end
        apb_read(16'h4004, rd, er);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_cmp0_hi: got %h required ffffffff", rd); end
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_mtime: got %h required 0", rd); end
        total++;
        if (timer_irq !== 4'h0 || sw_irq !== 4'h0) begin
            bad++; $display("FAIL reset_irqs_after: got %b/%b required 0000/0000", timer_irq, sw_irq);
        end
    endtask

    task automatic test_ticks;
        logic [31:0] rd;
        logic        er;
        int          seen;
        apb_write(16'h4004, 32'h0, 4'hf, er);
        apb_write(16'h4000, 32'h1, 4'hf, er);
        total++;
        if (timer_irq[0] !== 1'b0) begin bad++; $display("FAIL tick_pre_irq: got %b required 0", timer_irq[0]); end
        // MTIME moves SYNC_DEPTH+2 edges after rtc rises; timer_irq follows one edge later.
        @(posedge aclk); #1;
        rtc = 1'b1;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge aclk); #1;
            if (c == 4) rtc = 1'b0;
            if (timer_irq[0] && seen == 0) seen = c;
        end
        total++;
        if (seen != SYNC_DEPTH + 3) begin
            bad++; $display("FAIL tick_latency: got %0d required %0d", seen, SYNC_DEPTH + 3);
        end
        repeat (4) pulse();
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'd5) begin bad++; $display("FAIL tick_count_lo: got %h required 5", rd); end
        apb_read(16'hBFFC, rd, er);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL tick_count_hi: got %h required 0", rd); end
    endtask

    task automatic test_timer;
        logic er;
        apb_write(16'hBFF8, 32'h0, 4'hf, er);
        apb_write(16'hBFFC, 32'h0, 4'hf, er);
        apb_write(16'h4014, 32'h0, 4'hf, er);
        apb_write(16'h4010, 32'h3, 4'hf, er);
        total++;
        if (timer_irq !== 4'b0000) begin bad++; $display("FAIL timer_idle: got %b required 0000", timer_irq); end
        repeat (2) pulse();
        total++;
        if (timer_irq !== 4'b0001) begin bad++; $display("FAIL timer_at2: got %b required 0001", timer_irq); end
        @(posedge aclk); #1;
        rtc = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge aclk); #1;
            if (c == 4) begin
                rtc = 1'b0;
                total++;
                if (timer_irq[2] !== 1'b0) begin bad++; $display("FAIL timer_early: got %b required 0", timer_irq[2]); end
            end
            if (c == 5) begin
                total++;
                if (timer_irq !== 4'b0101) begin bad++; $display("FAIL timer_rise: got %b required 0101", timer_irq); end
            end
        end
        apb_write(16'h4010, 32'd10, 4'hf, er);
        total++;
        if (timer_irq[2] !== 1'b1) begin bad++; $display("FAIL timer_hold: got %b required 1", timer_irq[2]); end
        @(posedge aclk); #1;
        total++;
        if (timer_irq[2] !== 1'b0) begin bad++; $display("FAIL timer_drop: got %b required 0", timer_irq[2]); end
    endtask

    task automatic test_msip_err;
        logic [31:0] rd;
        logic        er;
        apb_write(16'h0004, 32'hFFFF_FFFF, 4'hf, er);
        total++;
        if (sw_irq !== 4'b0010 || er !== 1'b0) begin
            bad++; $display("FAIL msip_write: got %b/%b required 0010/0", sw_irq, er);
        end
        @(posedge aclk); #1;
        total++;
        if (slv_ready !== 1'b0) begin bad++; $display("FAIL ready_pulse: got %b required 0", slv_ready); end
        apb_read(16'h0004, rd, er);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL msip_read: got %h required 00000001", rd); end
        apb_write(16'h0010, 32'hFFFF_FFFF, 4'hf, er);
        total++;
        if (er !== 1'b1 || sw_irq !== 4'b0010) begin
            bad++; $display("FAIL msip_oob_write: got err=%b sw=%b required 1/0010", er, sw_irq);
        end
        apb_read(16'h0010, rd, er);
        total++;
        if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL msip_oob_read: got %h/%b required 0/1", rd, er); end
        apb_read(16'h0006, rd, er);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL misaligned: got %b required 1", er); end
        apb_read(16'h4020, rd, er);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL cmp_oob: got %b required 1", er); end
        apb_write(16'h000C, 32'h1, 4'b1110, er);
        total++;
        if (sw_irq !== 4'b0010) begin bad++; $display("FAIL msip_strobe: got %b required 0010", sw_irq); end
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'd3 || er !== 1'b0) begin bad++; $display("FAIL mtime_read: got %h/%b required 3/0", rd, er); end
    endtask

    task automatic test_wrap;
        logic [31:0] rd;
        logic        er;
        apb_write(16'hBFF8, 32'hFFFF_FFFF, 4'hf, er);
        apb_write(16'hBFFC, 32'hFFFF_FFFF, 4'hf, er);
        pulse();
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL wrap_lo: got %h required 0", rd); end
        apb_read(16'hBFFC, rd, er);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL wrap_hi: got %h required 0", rd); end
        // Place the write edge on the same edge the tick lands.
        @(posedge aclk); #1;
        rtc = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        apb_write(16'hBFF8, 32'h100, 4'hf, er);
        rtc = 1'b0;
        repeat (6) begin @(posedge aclk); #1; end
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'h100) begin bad++; $display("FAIL collision: got %h required 00000100", rd); end
        apb_write(16'hBFF8, 32'h1234_56AB, 4'b0001, er);
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'h1AB) begin bad++; $display("FAIL byte_write: got %h required 000001ab", rd); end
    endtask

    task automatic test_snapshot;
        logic [31:0] rd;
        logic        er;
        apb_write(16'hBFF8, 32'hFFFF_FFFF, 4'hf, er);
        apb_write(16'hBFFC, 32'h1, 4'hf, er);
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL snap_lo: got %h required ffffffff", rd); end
        pulse();
        apb_read(16'hBFFC, rd, er);
        total++;
`ifdef FRISCV_CLINT_SNAPSHOT_EN
        if (rd !== 32'h1) begin bad++; $display("FAIL snap_hi: got %h required 00000001", rd); end
`else
        if (rd !== 32'h2) begin bad++; $display("FAIL live_hi: got %h required 00000002", rd); end
`endif
        apb_read(16'hBFF8, rd, er);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL snap_lo_after: got %h required 0", rd); end
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_timer();
        test_msip_err();
        test_wrap();
        test_snapshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/friscv_clint_mh.md
# friscv_clint_mh

Multi-hart Core Local Interrupt Controller: one shared 64-bit MTIME counter, per-hart MTIMECMP and MSIP registers, and per-hart timer/software interrupt outputs. Registers are accessed over the platform APB slave port. The block sits between the APB interconnect and the interrupt inputs of every hart's CSR unit, replacing the single-hart controller. MTIME advances on synchronized rising edges of an external real-time-clock tick, and keeps counting during bus accesses.

## Interface
- ADDRW, 16: APB address width; must be ≥ 16.
- XLEN, 32: data width; legal values are 32 and 64.
- NHART, 4: number of harts served; legal range is 1..32.
- SYNC_DEPTH, 2: number of flip-flop stages in the rtc synchronizer; must be ≥ 2.
- aclk  in  1  Core clock.
- srst  in  1  Reset, synchronous and active-high. Clears all state on the next aclk edge.
- slv_en  in  1  APB access enable.
- slv_wr  in  1  1 = write, 0 = read.
- slv_addr  in  ADDRW  Byte address.
- slv_wdata  in  XLEN  Write data.
- slv_strb  in  XLEN/8  Byte write strobes.
- slv_rdata  out  XLEN  Read data. Valid while slv_ready is high.
- slv_ready  out  1  Access completion pulse.
- slv_err  out  1  Error flag for an unmapped or misaligned address. Valid while slv_ready is high.
- rtc  in  1  Asynchronous real-time-clock tick.
- sw_irq  out  NHART  Per-hart software interrupt (MSIP bit 0).
- timer_irq  out  NHART  Per-hart timer interrupt.

## Operation
- **Register map:**
  - MSIP[h] at 0x0000 + 4·h. 32-bit register; only bit 0 is implemented.
  - MTIMECMP[h] at 0x4000 + 8·h. 64-bit register.
  - MTIME at 0xBFF8. 64-bit register.
- **Access width:**
  - XLEN=32: each 64-bit register is two words, low word at +0 and high word at +4.
  - XLEN=64: 64-bit registers require 8-byte alignment. An MSIP access at an address that is not 8-byte aligned uses the lane at 4·h, i.e. byte lanes [7:4].
- **Unmapped addresses:** any other address, or h ≥ NHART, sets slv_err=1. Reads of such an address return 0; writes are ignored.
- **Writes** are byte-granular under slv_strb. Unimplemented MSIP bits read as 0.
- **rtc tick:** rtc passes through a SYNC_DEPTH-stage synchronizer followed by a one-stage edge detector. Each synchronized 0→1 transition increments MTIME by 1. MTIME wraps from 2^64−1 to 0.
- **Write vs. increment:** an APB write to any MTIME byte in the same cycle as a tick wins. The whole counter takes the written value with no increment, and unwritten bytes keep their old value.
- **Timer interrupt:** timer_irq[h] is the registered value of the unsigned 64-bit compare MTIME ≥ MTIMECMP[h]. It is re-evaluated every cycle.
- **Software interrupt:** sw_irq[h] is a direct register output of MSIP[h] bit 0.
- **Reset values:**
  - MTIME = 0.
  - MTIMECMP[h] = 64'hFFFF_FFFF_FFFF_FFFF, so no timer interrupt is raised after reset.
  - MSIP = 0.
  - All outputs are 0, including slv_rdata, slv_ready, slv_err, sw_irq and timer_irq.
  - Synchronizer and edge-detector stages are cleared to 0.

## Timing
- **Handshake:** slv_ready goes high in the cycle after slv_en is sampled high while slv_ready is low, and it lasts exactly 1 cycle. The master holds slv_en, slv_addr, slv_wr, slv_wdata and slv_strb stable until slv_ready. Back-to-back accesses therefore take 2 cycles each.
- **Write side effects** take place on the edge that raises slv_ready. slv_rdata and slv_err are registered on that same edge.
- **Latency:**
  - rtc edge to MTIME change: SYNC_DEPTH + 2 cycles.
  - MTIME or MTIMECMP change to timer_irq: 1 cycle.
  - MSIP write to sw_irq: 0 cycles after slv_ready, since both update on the same edge.
- **Register read values:** a read of MTIME returns the value held before that cycle's edge, ignoring any concurrent increment.
- **srst during an access:** the access is aborted, no slv_ready is produced, and the master must reissue the access.
- **Interrupt level:** timer_irq stays high for as long as the compare holds. Raising MTIMECMP above MTIME drops it 1 cycle after the write.

## Configuration
- **FRISCV_CLINT_SNAPSHOT_EN** is meaningful for XLEN=32 only; it has no effect for XLEN=64.
- **Defined:**
  - A read of the MTIME low word also copies MTIME[63:32] into a 32-bit shadow register, on the same edge.
  - A read of the MTIME high word returns the shadow, giving a coherent 64-bit sample.
  - Any write to MTIME updates the shadow with the newly written high word.
  - The shadow resets to 0.
- **Undefined:** a read of the MTIME high word returns the live MTIME[63:32]. Software must use the hi/lo/hi retry loop to get a coherent value.

## Test plan
- **Reset:** assert srst for 3 cycles. Expect all outputs 0, MTIMECMP[0] to read back as 0xFFFFFFFF on both words, and timer_irq=0 even with MTIME=0.
- **Tick counting:** apply 5 rtc pulses, each held 4 cycles high and 4 cycles low. MTIME low word reads 5; the rtc→count latency is exactly SYNC_DEPTH + 2 cycles.
- **Timer compare:** write MTIMECMP[2]=3 (high word 0), then tick 3 times. timer_irq[2] rises 1 cycle after MTIME becomes 3 and timer_irq[1] stays 0. Writing MTIMECMP[2]=10 clears timer_irq[2] 1 cycle later.
- **Software interrupt and error:**
  - Write MSIP[1]=0xFFFFFFFF: sw_irq=4'b0010, and a read returns 0x00000001.
  - Write MSIP[NHART] (address 0x0010 with NHART=4): slv_err=1 and sw_irq is unchanged.
- **Wrap and collision:**
  - Write MTIME=0xFFFFFFFF_FFFFFFFF, then tick once: MTIME=0.
  - Collide a write of 0x100 to the low word with a tick edge: MTIME=0x100.
- **Snapshot (macro defined, XLEN=32):**
  - Set MTIME=0x00000001_FFFFFFFF.
  - Read the low word, then tick once, then read the high word. The high word returns 0x00000001, not 0x00000002.
